lsq_multi_cdb: RTL

- Parametrised successor to the current load/store buffer: an in-order circular load/store queue of configurable depth.
- Snoops NUM_CDB broadcast channels per cycle, including same-cycle bypass into the entry being enqueued.
- Drives the single memory controller port through an explicit request FSM. Stores issue only at ROB head.
- Load results in flight at a flush are drained and never broadcast.

---
 rtl/lsq_multi_cdb.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsq_multi_cdb.sv
// lsq_multi_cdb: in-order circular load/store queue snooping NUM_CDB broadcast channels.
// Optional macro LSQ_IO_ORDER_EN holds MMIO loads (addr >= 0x30000) until they reach ROB head.
module lsq_multi_cdb #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ROB_TAG_W = 4,
   parameter int unsigned NUM_CDB   = 2
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        rdy_in,
   output logic                        lsb_full,
   output logic [$clog2(DEPTH):0]      lsb_count,
   input  logic                        task_in,
   input  logic [5:0]                  op_type,
   input  logic [31:0]                 vj_in,
   input  logic [31:0]                 vk_in,
   input  logic [ROB_TAG_W-1:0]        qj_in,
   input  logic [ROB_TAG_W-1:0]        qk_in,
   input  logic                        j_in,
   input  logic                        k_in,
   input  logic [31:0]                 imm_in,
   input  logic [ROB_TAG_W-1:0]        dest_in,
   output logic                        mem_req,
   input  logic                        mem_received,
   input  logic                        mem_has_result,
   input  logic [31:0]                 mem_rdata,
   output logic                        mem_we,
   output logic [2:0]                  mem_width,
   output logic [31:0]                 mem_addr,
   output logic [31:0]                 mem_wdata,
   input  logic [ROB_TAG_W-1:0]        rob_head,
   input  logic                        clear_all,
   input  logic [NUM_CDB-1:0]          cdb_valid,
   input  logic [NUM_CDB*ROB_TAG_W-1:0] cdb_tag,
   input  logic [NUM_CDB*32-1:0]       cdb_value,
   output logic                        load_valid,
   output logic [ROB_TAG_W-1:0]        load_tag,
   output logic [31:0]                 load_value,
   output logic                        store_done,
   output logic [ROB_TAG_W-1:0]        store_tag
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [5:0] OpLb = 6'd10, OpLh = 6'd11, OpLbu = 6'd13, OpLhu = 6'd14;
   localparam logic [5:0] OpSb = 6'd15, OpSh = 6'd16;

   typedef struct packed {
      logic                 busy;
      logic [5:0]           op;
      logic [31:0]          vj;
      logic [31:0]          vk;
      logic [31:0]          imm;
      logic [ROB_TAG_W-1:0] qj;
      logic [ROB_TAG_W-1:0] qk;
      logic [ROB_TAG_W-1:0] dest;
      logic                 j;
      logic                 k;
   } entry_t;

   typedef enum logic [1:0] {StIdle, StReq, StWaitLoad, StDrain} state_e;

   entry_t               ent_q [DEPTH];
   entry_t               ent_d [DEPTH];
   entry_t               hd, nw;
   logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]      count_q, count_d;
   state_e               state_q, state_d;
   logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [2:0]           mem_width_q, mem_width_d, hd_width;
   logic [31:0]          mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, hd_addr;
   logic                 load_valid_q, load_valid_d, store_done_q, store_done_d;
   logic [31:0]          load_value_q, load_value_d;
   logic [ROB_TAG_W-1:0] load_tag_q, load_tag_d, store_tag_q, store_tag_d, cur_tag_q, cur_tag_d;
   logic [5:0]           cur_op_q, cur_op_d;
   logic                 push, pop, hd_store, hd_ordered;
   logic [32:0]          sj, sk;

   // Returns {hit, value}; the load result is overridden by any CDB hit, lowest channel last.
   function automatic logic [32:0] snoop(input logic [ROB_TAG_W-1:0] tag,
                                         input logic [NUM_CDB-1:0] v,
                                         input logic [NUM_CDB*ROB_TAG_W-1:0] t,
                                         input logic [NUM_CDB*32-1:0] d,
                                         input logic lv,
                                         input logic [ROB_TAG_W-1:0] lt,
                                         input logic [31:0] ld);
      snoop = '0;
      if (lv && lt == tag) snoop = {1'b1, ld};
      for (int c = int'(NUM_CDB) - 1; c >= 0; c--) begin
         if (v[c] && t[c*ROB_TAG_W +: ROB_TAG_W] == tag) snoop = {1'b1, d[c*32 +: 32]};
      end
   endfunction

   function automatic logic [2:0] width_of(input logic [5:0] op);
      if (op == OpLb || op == OpLbu || op == OpSb) width_of = 3'd1;
      else if (op == OpLh || op == OpLhu || op == OpSh) width_of = 3'd2;
      else width_of = 3'd4;
   endfunction

   function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] r);
      case (op)
         OpLb:    extend = {{24{r[7]}}, r[7:0]};
         OpLh:    extend = {{16{r[15]}}, r[15:0]};
         OpLbu:   extend = {24'b0, r[7:0]};
         OpLhu:   extend = {16'b0, r[15:0]};
         default: extend = r;
      endcase
   endfunction

   assign hd       = ent_q[head_q];
   assign hd_addr  = hd.vj + hd.imm;
   assign hd_store = hd.op >= OpSb;
   assign hd_width = width_of(hd.op);
`ifdef LSQ_IO_ORDER_EN
   assign hd_ordered = hd_store || (hd_addr >= 32'h0003_0000);
`else
   assign hd_ordered = hd_store;
`endif

   always_comb begin
      ent_d        = ent_q;
      head_d       = head_q;
      tail_d       = tail_q;
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_width_d  = mem_width_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      load_valid_d = 1'b0;
      load_tag_d   = load_tag_q;
      load_value_d = load_value_q;
      store_done_d = 1'b0;
      store_tag_d  = store_tag_q;
      cur_op_d     = cur_op_q;
      cur_tag_d    = cur_tag_q;
      pop          = 1'b0;
      nw           = '0;
      sj           = '0;
      sk           = '0;

      for (int i = 0; i < int'(DEPTH); i++) begin
         if (ent_q[i].busy && !ent_q[i].j) begin
            sj = snoop(ent_q[i].qj, cdb_valid, cdb_tag, cdb_value, load_valid_q, load_tag_q,
                       load_value_q);
            if (sj[32]) begin
               ent_d[i].j  = 1'b1;
               ent_d[i].vj = sj[31:0];
            end
         end
         if (ent_q[i].busy && !ent_q[i].k) begin
            sk = snoop(ent_q[i].qk, cdb_valid, cdb_tag, cdb_value, load_valid_q, load_tag_q,
                       load_value_q);
            if (sk[32]) begin
               ent_d[i].k  = 1'b1;
               ent_d[i].vk = sk[31:0];
            end
         end
      end

      unique case (state_q)
         StIdle: begin
            if (hd.busy && hd.j && hd.k && (!hd_ordered || rob_head == hd.dest)) begin
               state_d     = StReq;
               mem_req_d   = 1'b1;
               mem_we_d    = hd_store;
               mem_width_d = hd_width;
               mem_addr_d  = hd_addr;
               mem_wdata_d = (hd_width == 3'd1) ? {24'b0, hd.vk[7:0]} :
                             (hd_width == 3'd2) ? {16'b0, hd.vk[15:0]} : hd.vk;
               cur_op_d    = hd.op;
               cur_tag_d   = hd.dest;
            end
         end
         StReq: begin
            if (mem_received) begin
               mem_req_d = 1'b0;
               pop       = 1'b1;
               if (mem_we_q) begin
                  store_done_d = 1'b1;
                  store_tag_d  = cur_tag_q;
                  state_d      = StIdle;
               end else begin
                  state_d = StWaitLoad;
               end
            end
         end
         StWaitLoad: begin
            if (mem_has_result) begin
               load_valid_d = 1'b1;
               load_tag_d   = cur_tag_q;
               load_value_d = extend(cur_op_q, mem_rdata);
               state_d      = StIdle;
            end
         end
         StDrain: begin
            if (mem_has_result) state_d = StIdle;
         end
      endcase

      push = task_in && !lsb_full;
      if (pop) begin
         ent_d[head_q].busy = 1'b0;
         head_d             = head_q + PtrW'(1);
      end
      if (push) begin
         sj      = snoop(qj_in, cdb_valid, cdb_tag, cdb_value, load_valid_q, load_tag_q,
                         load_value_q);
         sk      = snoop(qk_in, cdb_valid, cdb_tag, cdb_value, load_valid_q, load_tag_q,
                         load_value_q);
         nw.busy = 1'b1;
         nw.op   = op_type;
         nw.imm  = imm_in;
         nw.dest = dest_in;
         nw.qj   = qj_in;
         nw.qk   = qk_in;
         nw.j    = j_in || sj[32];
         nw.k    = k_in || sk[32];
         nw.vj   = (!j_in && sj[32]) ? sj[31:0] : vj_in;
         nw.vk   = (!k_in && sk[32]) ? sk[31:0] : vk_in;
         ent_d[tail_q] = nw;
         tail_d        = tail_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);

      if (clear_all) begin
         for (int i = 0; i < int'(DEPTH); i++) ent_d[i].busy = 1'b0;
         head_d       = '0;
         tail_d       = '0;
         count_d      = '0;
         mem_req_d    = 1'b0;
         load_valid_d = 1'b0;
         store_done_d = 1'b0;
         // A load already in memory must have its result swallowed before the next issue.
         if (((state_q == StWaitLoad || state_q == StDrain) && !mem_has_result) ||
             (state_q == StReq && !mem_we_q && mem_received)) state_d = StDrain;
         else state_d = StIdle;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         state_q      <= StIdle;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_width_q  <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         load_valid_q <= 1'b0;
         load_tag_q   <= '0;
         load_value_q <= '0;
         store_done_q <= 1'b0;
         store_tag_q  <= '0;
         cur_op_q     <= '0;
         cur_tag_q    <= '0;
      end else if (rdy_in) begin
         ent_q        <= ent_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_width_q  <= mem_width_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         load_valid_q <= load_valid_d;
         load_tag_q   <= load_tag_d;
         load_value_q <= load_value_d;
         store_done_q <= store_done_d;
         store_tag_q  <= store_tag_d;
         cur_op_q     <= cur_op_d;
         cur_tag_q    <= cur_tag_d;
      end
   end

   assign lsb_full   = count_q == CntW'(DEPTH);
   assign lsb_count  = count_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_width  = mem_width_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign load_valid = load_valid_q;
   assign load_tag   = load_tag_q;
   assign load_value = load_value_q;
   assign store_done = store_done_q;
   assign store_tag  = store_tag_q;

endmodule
